// File: rtl/tl_ram_pkg.sv
// Shared TileLink-UL opcodes and the D-channel beat type used by the
// RAM responder and its response queue.
package tl_ram_pkg;

  localparam int TL_SOURCE_W = 7;
  localparam int TL_SIZE_W   = 2;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_ARITHMETIC  = 3'd2;
  localparam logic [2:0] TL_LOGICAL     = 3'd3;
  localparam logic [2:0] TL_GET         = 3'd4;

  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   denied;
    logic [63:0]            data;
  } tl_d_beat_t;

endpackage

// File: rtl/tl_resp_queue.sv
// Two-entry D-beat FIFO built as a shift register so the head entry is
// always a flop and the D channel is driven straight from registers.
module tl_resp_queue
  import tl_ram_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  tl_d_beat_t push_beat,
  input  logic       pop,
  output tl_d_beat_t head_beat,
  output logic       head_valid,
  output logic [1:0] count
);

  tl_d_beat_t entry0_r;
  tl_d_beat_t entry1_r;
  logic [1:0] count_r;

  // Queue storage and occupancy; push into a full queue is excluded by the A credit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry0_r <= '0;
      entry1_r <= '0;
      count_r  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            entry0_r <= push_beat;
          end else begin
            entry1_r <= push_beat;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          entry0_r <= entry1_r;
          count_r  <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            entry0_r <= push_beat;
          end else begin
            entry0_r <= entry1_r;
            entry1_r <= push_beat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_beat  = entry0_r;
  assign head_valid = (count_r != 2'd0);
  assign count      = count_r;

endmodule

// File: rtl/tl_ram_responder.sv
// TileLink-UL responder: single-beat Get/Put against a local synchronous RAM,
// one D beat per A beat, decoupled from d_ready by a two-entry queue.
module tl_ram_responder
  import tl_ram_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int SOURCE_W = 7,
  parameter int SIZE_W   = 2,
  parameter int DEPTH    = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_bits_opcode,
  input  logic [2:0]          a_bits_param,
  input  logic [SIZE_W-1:0]   a_bits_size,
  input  logic [SOURCE_W-1:0] a_bits_source,
  input  logic [ADDR_W-1:0]   a_bits_address,
  input  logic [7:0]          a_bits_mask,
  input  logic [63:0]         a_bits_data,
  input  logic                a_bits_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_bits_opcode,
  output logic [SIZE_W-1:0]   d_bits_size,
  output logic [SOURCE_W-1:0] d_bits_source,
  output logic                d_bits_denied,
  output logic                d_bits_corrupt,
  output logic [63:0]         d_bits_data
);

  localparam int              IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] RAM_BYTES = (ADDR_W + 1)'(DEPTH * 8);

  logic                a_fire_s, is_get_s, is_put_s, denied_s, ram_wr_s, ram_rd_s;
  logic [2:0]          resp_opcode_s;
  logic [IDX_W-1:0]    idx_s;
  logic                stage_valid_r, stage_denied_r, stage_has_data_r;
  logic [2:0]          stage_opcode_r;
  logic [SIZE_W-1:0]   stage_size_r;
  logic [SOURCE_W-1:0] stage_source_r;
  logic [63:0]         ram_r [DEPTH];
  logic [63:0]         rdata_r;
  tl_d_beat_t          enq_beat_s, head_beat_s;
  logic                head_valid_s, pop_s, a_ready_r;
  logic [1:0]          count_s;
  logic [2:0]          count_next_s;
  logic                unused_s;

  // Decode the A beat into RAM strobes and the response shape.
  always_comb begin
    a_fire_s = a_valid && a_ready_r;
    is_get_s = (a_bits_opcode == TL_GET);
    is_put_s = (a_bits_opcode == TL_PUT_FULL) || (a_bits_opcode == TL_PUT_PARTIAL);
    denied_s = ({1'b0, a_bits_address} >= RAM_BYTES) || !(is_get_s || is_put_s);
    ram_wr_s = a_fire_s && is_put_s && !denied_s && !a_bits_corrupt;
    ram_rd_s = a_fire_s && is_get_s && !denied_s;
    idx_s    = a_bits_address[IDX_W+2:3];
    if (is_get_s || (a_bits_opcode == TL_ARITHMETIC) || (a_bits_opcode == TL_LOGICAL)) begin
      resp_opcode_s = TL_ACCESS_ACK_DATA;
    end else begin
      resp_opcode_s = TL_ACCESS_ACK;
    end
  end

  // Scratchpad RAM; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_wr_s) begin
      for (int b = 0; b < 8; b++) begin
        if (a_bits_mask[b]) begin
          ram_r[idx_s][b*8 +: 8] <= a_bits_data[b*8 +: 8];
        end
      end
    end
    if (ram_rd_s) begin
      rdata_r <= ram_r[idx_s];
    end
  end

  // Stage register holding the response header while the RAM read completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid_r    <= 1'b0;
      stage_opcode_r   <= 3'd0;
      stage_size_r     <= '0;
      stage_source_r   <= '0;
      stage_denied_r   <= 1'b0;
      stage_has_data_r <= 1'b0;
    end else begin
      stage_valid_r <= a_fire_s;
      if (a_fire_s) begin
        stage_opcode_r   <= resp_opcode_s;
        stage_size_r     <= a_bits_size;
        stage_source_r   <= a_bits_source;
        stage_denied_r   <= denied_s;
        stage_has_data_r <= ram_rd_s;
      end
    end
  end

  // Assemble the beat to enqueue; only a successful Get carries RAM data.
  always_comb begin
    enq_beat_s        = '0;
    enq_beat_s.opcode = stage_opcode_r;
    enq_beat_s.size   = stage_size_r;
    enq_beat_s.source = stage_source_r;
    enq_beat_s.denied = stage_denied_r;
    if (stage_has_data_r) begin
      enq_beat_s.data = rdata_r;
    end else begin
      enq_beat_s.data = 64'h0;
    end
  end

  tl_resp_queue u_resp_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (stage_valid_r),
    .push_beat  (enq_beat_s),
    .pop        (pop_s),
    .head_beat  (head_beat_s),
    .head_valid (head_valid_s),
    .count      (count_s)
  );

  assign pop_s        = head_valid_s && d_ready;
  assign count_next_s = {1'b0, count_s} + {2'b00, stage_valid_r} - {2'b00, pop_s};

  // a_ready is registered as next cycle's (queue count + stage_valid) < 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_ready_r <= 1'b1;
    end else begin
      a_ready_r <= ((count_next_s + {2'b00, a_fire_s}) < 3'd2);
    end
  end

  assign a_ready        = a_ready_r;
  assign d_valid        = head_valid_s;
  assign d_bits_opcode  = head_beat_s.opcode;
  assign d_bits_size    = head_beat_s.size;
  assign d_bits_source  = head_beat_s.source;
  assign d_bits_denied  = head_beat_s.denied;
  assign d_bits_corrupt = 1'b0;
  assign d_bits_data    = head_beat_s.data;
  assign unused_s       = ^a_bits_param;

endmodule
